// File: rtl/led_ser_pkg.sv
// Shared types and sizing helpers for the LED word serializer.
// Build option LED_SER_ABS_SAT_EN is consumed by abs_nbit.
package led_ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic int idx_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

  // One counter serves both bit hold and gap, sized for the longer one.
  function automatic int cnt_w(input int t, input int g);
    int m;
    m = (t > g) ? t : g;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/abs_nbit.sv
// WIDTH-bit two's complement magnitude with most-negative detect.
// LED_SER_ABS_SAT_EN: most-negative saturates to max positive.
module abs_nbit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MINV =
    {1'b1, {(WIDTH-1){1'b0}}};

  assign ovf = (in == MINV);

  always_comb begin
    out = in[WIDTH-1] ? (~in + WIDTH'(1)) : in;
`ifdef LED_SER_ABS_SAT_EN
    if (ovf) out = ~MINV;
`else
    // negation of MINV wraps back to MINV
`endif
  end

endmodule

// File: rtl/led_word_serializer.sv
// Serialises a WIDTH-bit word onto one LED pin, bit by bit.
// Build option LED_SER_ABS_SAT_EN selects saturating abs.
module led_word_serializer
  import led_ser_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int TICKS_PER_BIT = 1250,
  parameter int GAP_TICKS     = 2500,
  parameter int LSB_FIRST     = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     abs_mode,
  output logic                     led,
  output logic                     busy,
  output logic [$clog2(WIDTH)-1:0] bit_idx,
  output logic                     done,
  output logic                     abs_ovf
);

  localparam int IW = idx_w(WIDTH);
  localparam int CW = cnt_w(TICKS_PER_BIT, GAP_TICKS);
  localparam logic [CW-1:0] TLAST =
    CW'(TICKS_PER_BIT - 1);
  localparam logic [CW-1:0] GLAST =
    (GAP_TICKS > 0) ? CW'(GAP_TICKS - 1) : '0;
  localparam logic [IW-1:0] IDX_FIRST =
    (LSB_FIRST != 0) ? '0 : IW'(WIDTH - 1);
  localparam logic [IW-1:0] IDX_LAST =
    (LSB_FIRST != 0) ? IW'(WIDTH - 1) : '0;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [IW-1:0]    idx_n;
  logic             done_n, ovf_n;
  logic [WIDTH-1:0] mag, word;
  logic             aovf;
  logic             accept;

  abs_nbit #(.WIDTH(WIDTH)) u_abs (
    .in  (in_data),
    .out (mag),
    .ovf (aovf)
  );

  assign word     = abs_mode ? mag : in_data;
  assign in_ready = (state == IDLE) && !clear;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);
  assign led      = (state == SHIFT) &&
                    ((LSB_FIRST != 0) ? sreg[0]
                                      : sreg[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      sreg    <= '0;
      bit_idx <= '0;
      done    <= 1'b0;
      abs_ovf <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sreg    <= sreg_n;
      bit_idx <= idx_n;
      done    <= done_n;
      abs_ovf <= ovf_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sreg_n  = sreg;
    idx_n   = bit_idx;
    done_n  = 1'b0;
    ovf_n   = abs_ovf;
    if (clear && state != IDLE) begin
      state_n = IDLE;
      cnt_n   = '0;
      sreg_n  = '0;
      idx_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state_n = SHIFT;
            cnt_n   = '0;
            sreg_n  = word;
            idx_n   = IDX_FIRST;
            ovf_n   = abs_mode & aovf;
          end
        end
        SHIFT: begin
          if (cnt == TLAST) begin
            cnt_n = '0;
            if (bit_idx == IDX_LAST) begin
              sreg_n = '0;
              idx_n  = '0;
              if (GAP_TICKS == 0) begin
                state_n = IDLE;
                done_n  = 1'b1;
              end else begin
                state_n = GAP;
              end
            end else if (LSB_FIRST != 0) begin
              sreg_n = sreg >> 1;
              idx_n  = bit_idx + IW'(1);
            end else begin
              sreg_n = sreg << 1;
              idx_n  = bit_idx - IW'(1);
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        GAP: begin
          if (cnt == GLAST) begin
            state_n = IDLE;
            cnt_n   = '0;
            done_n  = 1'b1;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_word_serializer.sv
// Scoreboard bench: LSB-first/gap and MSB-first/no-gap instances.
// Expected per-cycle LED trace is built from the word at accept.
module tb_led_word_serializer;

  typedef struct {
    logic       led;
    logic [2:0] idx;
    logic       ck;
    logic       last;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input int inst, input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL i%0d %s got=%0h exp=%0h t=%0t",
               inst, nm, act, exp, $time);
    end
  endtask

  genvar g;
  for (g = 0; g < 2; g++) begin : gi
    localparam int LSB = (g == 0) ? 1 : 0;
    localparam int GP  = (g == 0) ? 3 : 0;

    logic       rst_n, clear, in_valid, in_ready;
    logic       abs_mode, led, busy, done, abs_ovf;
    logic [7:0] in_data;
    logic [2:0] bit_idx;

    ent_t q[$];
    logic cur_busy = 1'b0;
    logic last_f   = 1'b0;
    logic exp_ovf  = 1'b0;
    logic fin_l    = 1'b0;

    led_word_serializer #(
      .WIDTH(8), .TICKS_PER_BIT(4),
      .GAP_TICKS(GP), .LSB_FIRST(LSB)
    ) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .abs_mode(abs_mode),
      .led(led), .busy(busy), .bit_idx(bit_idx),
      .done(done), .abs_ovf(abs_ovf)
    );

    initial begin : mon
      ent_t e;
      logic ed;
      forever begin
        @(negedge clk);
        ed = last_f;
        if (q.size() > 0) begin
          e = q.pop_front();
          cur_busy = 1'b1;
          last_f = e.last;
          chk(g, "led", led, e.led);
          chk(g, "busy", busy, 1'b1);
          chk(g, "done", done, ed);
          if (e.ck) chk(g, "bit_idx", bit_idx, e.idx);
        end else begin
          cur_busy = 1'b0;
          last_f = 1'b0;
          chk(g, "idle_led", led, 1'b0);
          chk(g, "idle_busy", busy, 1'b0);
          chk(g, "done", done, ed);
          chk(g, "idle_idx", bit_idx, 3'd0);
        end
        chk(g, "abs_ovf", abs_ovf, exp_ovf);
      end
    end

    task automatic push(input logic [7:0] d,
                        input logic am);
      logic [7:0] w;
      logic ov;
      ent_t e;
      ov = am && (d == 8'h80);
      w = (am && d[7]) ? 8'(8'd0 - d) : d;
`ifdef LED_SER_ABS_SAT_EN
      if (ov) w = 8'h7F;
`endif
      exp_ovf = ov;
      for (int k = 0; k < 8; k++)
        for (int t = 0; t < 4; t++) begin
          e.led  = w[(LSB != 0) ? k : 7 - k];
          e.idx  = 3'((LSB != 0) ? k : 7 - k);
          e.ck   = 1'b1;
          e.last = 1'b0;
          q.push_back(e);
        end
      for (int t = 0; t < GP; t++) begin
        e.led = 1'b0; e.idx = 3'd0;
        e.ck = 1'b0; e.last = 1'b0;
        q.push_back(e);
      end
      q[q.size()-1].last = 1'b1;
    endtask

    task automatic step(input logic v,
                        input logic [7:0] d,
                        input logic am,
                        input logic cl,
                        output logic acc);
      logic er;
      @(negedge clk);
      #1;
      in_valid = v; in_data = d;
      abs_mode = am; clear = cl;
      if (cl && cur_busy) begin
        q.delete();
        last_f = 1'b0;
      end
      er = !cur_busy && !cl;
      #1;
      chk(g, "in_ready", in_ready, er);
      acc = er && v && rst_n;
      if (acc) push(d, am);
    endtask

    task automatic idle(input int n);
      logic a;
      repeat (n) step(1'b0, 8'($urandom), 1'b0, 1'b0, a);
    endtask

    task automatic send(input logic [7:0] d,
                        input logic am);
      logic a;
      int n;
      a = 1'b0; n = 0;
      while (!a && n < 300) begin
        step(1'b1, d, am, 1'b0, a);
        n++;
      end
      if (!a) begin
        total++; bad++;
        $display("FAIL i%0d send_timeout got=busy exp=accept", g);
      end
    endtask

    task automatic drain();
      int n;
      n = 0;
      while ((cur_busy || q.size() > 0) && n < 300) begin
        idle(1);
        n++;
      end
      idle(1);
      if (n >= 300) begin
        total++; bad++;
        $display("FAIL i%0d drain_timeout got=busy exp=idle", g);
      end
    endtask

    initial begin : drv
      logic a, v, cl, am;
      logic [7:0] d;
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
      in_data = 8'h00; abs_mode = 1'b0;
      #1;
      chk(g, "rst_led", led, 1'b0);
      chk(g, "rst_busy", busy, 1'b0);
      chk(g, "rst_done", done, 1'b0);
      chk(g, "rst_idx", bit_idx, 3'd0);
      chk(g, "rst_ovf", abs_ovf, 1'b0);
      idle(2);
      rst_n = 1'b1;
      idle(2);
      send(8'hCB, 1'b0); drain();
      send(8'hCB, 1'b1); drain();
      send(8'h80, 1'b1); drain();
      send(8'hA5, 1'b0);
      send(8'h3C, 1'b0); drain();
      send(8'h5A, 1'b0); idle(3);
      step(1'b1, 8'hFF, 1'b0, 1'b0, a);
      step(1'b1, 8'hFF, 1'b1, 1'b0, a);
      idle(5);
      step(1'b1, 8'hFF, 1'b0, 1'b0, a);
      drain();
      send(8'hE7, 1'b0); idle(14);
      step(1'b0, 8'h00, 1'b0, 1'b1, a);
      idle(1); drain();
      send(8'h80, 1'b1);
      idle(31 + GP - GP / 2);
      @(negedge clk);
      #1;
      in_valid = 1'b0; clear = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk(g, "arst_led", led, 1'b0);
      chk(g, "arst_busy", busy, 1'b0);
      chk(g, "arst_idx", bit_idx, 3'd0);
      chk(g, "arst_done", done, 1'b0);
      chk(g, "arst_ovf", abs_ovf, 1'b0);
      q.delete();
      last_f = 1'b0; exp_ovf = 1'b0; cur_busy = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(1);
      for (int i = 0; i < 1200; i++) begin
        cl = ($urandom_range(0, 59) == 0);
        v  = ($urandom_range(0, 2) != 0);
        d  = 8'($urandom);
        if ($urandom_range(0, 9) == 0) d = 8'h80;
        am = 1'($urandom_range(0, 1));
        step(v, d, am, cl, a);
      end
      drain();
      fin_l = 1'b1;
    end
  end

  initial begin : main
    int n;
    n = 0;
    while (!(gi[0].fin_l && gi[1].fin_l) && n < 60000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 60000) begin
      total++; bad++;
      $display("FAIL global_timeout got=%0d exp=<60000", n);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_word_serializer.md
Name: led_word_serializer

Overview:
- Parametrised successor to the fixed 32-bit abs-and-blink debug path.
- Accepts a WIDTH-bit word over a valid/ready handshake and optionally converts it from two's complement to magnitude.
- Shifts the word out one bit at a time on a single LED pin; each bit is held for a programmable number of clock ticks, followed by an inter-word low gap.
- Sits between on-chip datapath test logic and a board LED on iCE40 designs clocked from the low-frequency oscillator.

Parameters:
- WIDTH, 32, data word width in bits (>=2).
- TICKS_PER_BIT, 1250, clock cycles each bit is held on led (>=1).
- GAP_TICKS, 2500, cycles of forced-low led after the last bit (>=0; 0 skips the gap).
- LSB_FIRST, 1, 1 = bit 0 shifted first, 0 = bit WIDTH-1 first.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort; returns to idle.
- in_valid  input  1  word offered.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  word to display.
- abs_mode  input  1  1 = display |in_data| (two's complement), 0 = raw.
- led  output  1  serial LED drive.
- busy  output  1  word in progress (SHIFT or GAP).
- bit_idx  output  $clog2(WIDTH)  index of the bit currently on led.
- done  output  1  one-cycle pulse at word completion.
- abs_ovf  output  1  accepted word was the most-negative value in abs_mode.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, led=0, busy=0, done=0, bit_idx=0, abs_ovf=0, tick counter=0, shift register=0.
- in_ready = (state==IDLE) && !clear.
- Accept occurs on a clock edge where in_valid && in_ready.
  - in_data and abs_mode are sampled together; later changes do not affect the word in flight.
  - in_valid is ignored while busy.
- States:
  - IDLE -> SHIFT on accept.
  - SHIFT -> GAP after the last bit's final tick (-> IDLE directly if GAP_TICKS==0).
  - GAP -> IDLE after GAP_TICKS cycles.
- Timing:
  - The cycle after accept, led shows the first bit and bit_idx = 0 (LSB_FIRST) or WIDTH-1.
  - Each bit is held exactly TICKS_PER_BIT cycles; bit_idx steps by +1 (LSB_FIRST) or -1 at each bit boundary.
  - led=0 throughout GAP.
  - Total busy time = WIDTH*TICKS_PER_BIT + GAP_TICKS cycles.
- done:
  - Pulses high for the single cycle in which state returns to IDLE, which is also the first cycle in_ready is high again.
  - Back-to-back words are possible: a new accept can occur in that same cycle.
- Abs:
  - Magnitude = in_data[WIDTH-1] ? (~in_data + 1) : in_data, truncated to WIDTH bits.
  - Most-negative input (only MSB set) wraps to itself; abs_ovf=1 for that word.
  - abs_ovf updates at each accept and holds until the next accept or reset.
- clear:
  - Asserted in SHIFT or GAP: next cycle state=IDLE, led=0, bit_idx=0, no done pulse; abs_ovf is kept.
  - Asserted in IDLE with in_valid high: no accept.
- Tick counter is WIDTH-independent: $clog2(max(TICKS_PER_BIT, GAP_TICKS, 2)) bits, reused across SHIFT and GAP.

Optional Feature:
- Macro: LED_SER_ABS_SAT_EN.
- Defined: most-negative input in abs_mode saturates to the largest positive value (MSB=0, all other bits 1); abs_ovf still asserts.
- Undefined: wrap behaviour as above.
- Raw mode (abs_mode=0) is unaffected either way.

Decomposition:
- Package led_ser_pkg:
  - state enum (IDLE, SHIFT, GAP).
  - function for the index width.
- Sub-module abs_nbit:
  - Combinational, parameter WIDTH.
  - Ports: in, out, ovf.
  - Contains the LED_SER_ABS_SAT_EN branch.
  - Generalised replacement for the fixed 32-bit abs unit; instantiated once on the in_data path before the shift register.

Test Plan (WIDTH=8, TICKS_PER_BIT=4, GAP_TICKS=3, LSB_FIRST=1 unless stated):
- Raw word: accept 0xCB, abs_mode=0 -> led = 1,1,0,1,0,0,1,1 (each bit 4 cycles), 3 cycles low; done pulses 35 cycles after accept; abs_ovf=0.
- Abs word: accept 0xCB, abs_mode=1 -> magnitude 0x35; led = 1,0,1,0,1,1,0,0; abs_ovf=0.
- Most-negative: accept 0x80, abs_mode=1 -> wrap build: led shows 0x80 (7 zeros then 1); saturating build: 0x7F (seven 1s then 0); abs_ovf=1 in both builds.
- MSB-first and handshake: LSB_FIRST=0, GAP_TICKS=0, in_valid held high with 0xA5 then 0x3C -> led 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0 with no idle cycle between words; in_ready low for 32 cycles per word.
- Abort and reset: clear at tick 2 of bit 3 -> led=0 and in_ready=1 next cycle, no done pulse. rst_n low mid-GAP -> all outputs zero immediately, asynchronously of clk.
- Busy ignore: pulse in_valid with 0xFF during SHIFT -> not accepted; in-flight word completes unchanged.
